bus_rr_xbar: RTL and testbench
==============================

Name: bus_rr_xbar

Overview:
- Parametrised successor to the system's fixed-priority shared bus.
- Connects NrHosts hosts to NrDevices memory-mapped devices.
- Adds:
  - round-robin arbitration;
  - variable device response latency, with an explicit WAIT state;
  - an internally generated error response for unmapped addresses;
  - an optional response timeout.
- Sits between the core data port, the debug-module SBA host and all peripherals in the demo system top.

Parameters:
- NrHosts, 3, number of bus hosts (≥1).
- NrDevices, 7, number of bus devices (≥1).
- DataWidth, 32, data bus width.
- AddressWidth, 32, address bus width.
- TimeoutCycles, 255, WAIT cycles before a forced error response (used only with BUS_TIMEOUT_EN; ≥1).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- host_req_i  in  [NrHosts] x 1  host request
- host_gnt_o  out  [NrHosts] x 1  grant, combinational, same cycle as accepted request
- host_addr_i  in  [NrHosts] x AddressWidth  byte address
- host_we_i  in  [NrHosts] x 1  write enable
- host_be_i  in  [NrHosts] x DataWidth/8  byte enables
- host_wdata_i  in  [NrHosts] x DataWidth  write data
- host_rvalid_o  out  [NrHosts] x 1  response valid
- host_rdata_o  out  [NrHosts] x DataWidth  read data
- host_err_o  out  [NrHosts] x 1  error, qualified by rvalid
- device_req_o  out  [NrDevices] x 1  device request, single-cycle pulse
- device_addr_o  out  [NrDevices] x AddressWidth  forwarded address
- device_we_o  out  [NrDevices] x 1  forwarded write enable
- device_be_o  out  [NrDevices] x DataWidth/8  forwarded byte enables
- device_wdata_o  out  [NrDevices] x DataWidth  forwarded write data
- device_rvalid_i  in  [NrDevices] x 1  device response valid
- device_rdata_i  in  [NrDevices] x DataWidth  device read data
- device_err_i  in  [NrDevices] x 1  device error
- cfg_device_addr_base  in  [NrDevices] x AddressWidth  device base address
- cfg_device_addr_mask  in  [NrDevices] x AddressWidth  device address mask

Behaviour:
- Clock and reset: one clock, clk_i; rst_i is synchronous and active-high.
- Reset:
  - State goes to IDLE and the round-robin pointer to 0.
  - All registered state is cleared.
  - While rst_i is high, every host_gnt_o, host_rvalid_o, host_err_o and device_req_o is 0, and all rdata outputs are 0.
  - Reset mid-transaction abandons the transaction; no response is ever issued for it.
- Address decode:
  - Device d hits when (addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d].
  - If several devices hit, the lowest index wins.
  - No hit is a decode error.
- Arbitration, in IDLE only:
  - Among asserted host_req_i, grant the first host at or after rr_ptr, searching upward with wrap.
  - After granting host h, rr_ptr becomes (h+1) mod NrHosts.
  - Exactly one host_gnt_o is high, in the same cycle as its request.
- IDLE with a grant to a decoded device d:
  - device_req_o[d] is 1 for that cycle only.
  - device_addr_o, device_we_o, device_be_o and device_wdata_o of d equal the granted host's inputs.
  - Register host_q=h and dev_q=d, then go to WAIT.
  - All other device_req_o are 0. Non-selected device data outputs are 0.
- IDLE with a grant that is a decode error:
  - No device_req_o.
  - Go to ERR_RESP.
- ERR_RESP, one cycle:
  - host_rvalid_o[host_q]=1, host_err_o[host_q]=1, host_rdata_o[host_q]=0.
  - Next state is IDLE.
  - No grant this cycle.
- WAIT:
  - No grants.
  - When device_rvalid_i[dev_q]=1, drive host_rvalid_o[host_q]=1, host_rdata_o[host_q]=device_rdata_i[dev_q] and host_err_o[host_q]=device_err_i[dev_q] combinationally in the same cycle, then go to IDLE.
- Stray responses: device_rvalid_i from any device other than dev_q in WAIT, or from any device in IDLE/ERR_RESP, is ignored.
- Latency and throughput:
  - Minimum latency, grant to rvalid, is 1 cycle (device answering next cycle).
  - Maximum throughput is one transaction per 2 cycles.
  - A request arriving in the cycle a response completes waits for IDLE on the next cycle.
- Idle outputs: host_rvalid_o, host_err_o and host_rdata_o are 0 for every host not being responded to.
- Host obligations: hosts hold req/addr/we/be/wdata stable until granted (the host's contract; not checked here).

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- When defined:
  - A counter, width $clog2(TimeoutCycles+1), clears on entry to WAIT and increments every WAIT cycle without a response.
  - When it reaches TimeoutCycles and device_rvalid_i[dev_q]=0, respond host_rvalid_o[host_q]=1, host_err_o[host_q]=1, host_rdata_o[host_q]=0, and go to IDLE.
  - A response arriving in the same cycle as the timeout takes precedence and is forwarded normally.
  - A late response after a timeout is ignored per the stray rule.
- When undefined:
  - No counter is present.
  - WAIT persists until device_rvalid_i[dev_q].

Test Plan:
- Reset then single read: host0 reads 0x00100004 mapped to Ram (index 0); device answers next cycle with 0xDEADBEEF → host_gnt_o[0] in cycle 0, device_req_o[0] one-cycle pulse, host_rvalid_o[0]=1 with rdata 0xDEADBEEF and err=0 in cycle 1.
- Round-robin: hosts 0, 1 and 2 all request continuously after reset → grant order 0,1,2,0, one grant every 2 cycles with single-cycle devices; rr_ptr wraps to 0.
- Unmapped address: host1 writes 0x40000000 → no device_req_o asserted; next cycle host_rvalid_o[1]=1, host_err_o[1]=1, rdata=0.
- Variable latency and stray responses: device Timer responds after 5 cycles; device Gpio pulses rvalid during the wait → host receives only the Timer data on cycle 5; no grant to a waiting host1 until the cycle after.
- BUS_TIMEOUT_EN with TimeoutCycles=4: device never responds → err response exactly 4 WAIT cycles after grant; a device rvalid on cycle 6 is ignored. Without the macro, the bus stays in WAIT indefinitely.
- Reset mid-WAIT: rst_i pulsed for one cycle while in WAIT → no host_rvalid_o for the abandoned transaction; the next request is granted to host0 (rr_ptr=0).

Source files
------------

// File: rtl/bus_rr_xbar.sv
// Round-robin shared bus crossbar: NrHosts hosts to NrDevices memory-mapped devices.
// One transaction in flight at a time; variable device latency via a WAIT state,
// internally generated error responses for unmapped addresses.
// Optional feature macro: BUS_TIMEOUT_EN (forces an error response after
// TimeoutCycles WAIT cycles without a device response).
module bus_rr_xbar #(
    parameter int unsigned NrHosts       = 3,
    parameter int unsigned NrDevices     = 7,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned AddressWidth  = 32,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,

    input  logic [NrHosts-1:0]                       host_req_i,
    output logic [NrHosts-1:0]                       host_gnt_o,
    input  logic [NrHosts-1:0][AddressWidth-1:0]     host_addr_i,
    input  logic [NrHosts-1:0]                       host_we_i,
    input  logic [NrHosts-1:0][DataWidth/8-1:0]      host_be_i,
    input  logic [NrHosts-1:0][DataWidth-1:0]        host_wdata_i,
    output logic [NrHosts-1:0]                       host_rvalid_o,
    output logic [NrHosts-1:0][DataWidth-1:0]        host_rdata_o,
    output logic [NrHosts-1:0]                       host_err_o,

    output logic [NrDevices-1:0]                     device_req_o,
    output logic [NrDevices-1:0][AddressWidth-1:0]   device_addr_o,
    output logic [NrDevices-1:0]                     device_we_o,
    output logic [NrDevices-1:0][DataWidth/8-1:0]    device_be_o,
    output logic [NrDevices-1:0][DataWidth-1:0]      device_wdata_o,
    input  logic [NrDevices-1:0]                     device_rvalid_i,
    input  logic [NrDevices-1:0][DataWidth-1:0]      device_rdata_i,
    input  logic [NrDevices-1:0]                     device_err_i,

    input  logic [NrDevices-1:0][AddressWidth-1:0]   cfg_device_addr_base,
    input  logic [NrDevices-1:0][AddressWidth-1:0]   cfg_device_addr_mask
);

    localparam int unsigned HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int unsigned DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

    // Elaboration-time parameter sanity checks
    if (NrHosts < 1) begin : g_bad_hosts
        $error("bus_rr_xbar: NrHosts must be >= 1");
    end
    if (NrDevices < 1) begin : g_bad_devices
        $error("bus_rr_xbar: NrDevices must be >= 1");
    end
    if (TimeoutCycles < 1) begin : g_bad_timeout
        $error("bus_rr_xbar: TimeoutCycles must be >= 1");
    end

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWait    = 2'd1,
        StErrResp = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [HostIdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [HostIdxW-1:0]   host_q, host_d;
    logic [DevIdxW-1:0]    dev_q, dev_d;

    logic                  arb_valid;
    logic [HostIdxW-1:0]   arb_idx;
    logic [HostIdxW-1:0]   rr_next;
    int unsigned           arb_pos;

    logic [AddressWidth-1:0] sel_addr;
    logic                    dec_hit;
    logic [DevIdxW-1:0]      dec_idx;

    logic                  rsp_valid;
    logic [DataWidth-1:0]  rsp_data;
    logic                  rsp_err;

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_hit;

    // Timeout fires on the TimeoutCycles-th WAIT cycle without a response
    assign timeout_hit = (cnt_q == CntW'(TimeoutCycles - 1));
`endif

    // Round-robin search: first requesting host at or after rr_ptr_q, with wrap
    always_comb begin
        arb_valid = 1'b0;
        arb_idx   = '0;
        arb_pos   = 0;
        for (int unsigned i = 0; i < NrHosts; i++) begin
            arb_pos = 32'(rr_ptr_q) + i;
            if (arb_pos >= NrHosts) begin
                arb_pos = arb_pos - NrHosts;
            end
            if (!arb_valid && host_req_i[HostIdxW'(arb_pos)]) begin
                arb_valid = 1'b1;
                arb_idx   = HostIdxW'(arb_pos);
            end
        end
    end

    // Pointer value after granting arb_idx
    always_comb begin
        rr_next = HostIdxW'(arb_idx + HostIdxW'(1));
        if (arb_idx == HostIdxW'(NrHosts - 1)) begin
            rr_next = '0;
        end
    end

    // Address decode of the candidate host; lowest matching device index wins
    always_comb begin
        sel_addr = host_addr_i[arb_idx];
        dec_hit  = 1'b0;
        dec_idx  = '0;
        for (int unsigned d = 0; d < NrDevices; d++) begin
            if (!dec_hit &&
                ((sel_addr & cfg_device_addr_mask[DevIdxW'(d)]) == cfg_device_addr_base[DevIdxW'(d)])) begin
                dec_hit = 1'b1;
                dec_idx = DevIdxW'(d);
            end
        end
    end

    // Response from the device that owns the outstanding transaction
    always_comb begin
        rsp_valid = device_rvalid_i[dev_q];
        rsp_data  = device_rdata_i[dev_q];
        rsp_err   = device_err_i[dev_q];
    end

    // State register and transaction bookkeeping flops
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            host_q   <= '0;
            dev_q    <= '0;
`ifdef BUS_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            host_q   <= host_d;
            dev_q    <= dev_d;
`ifdef BUS_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        host_d   = host_q;
        dev_d    = dev_q;
`ifdef BUS_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    host_d   = arb_idx;
                    rr_ptr_d = rr_next;
                    if (dec_hit) begin
                        dev_d   = dec_idx;
                        state_d = StWait;
`ifdef BUS_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d = StErrResp;
                    end
                end
            end
            StWait: begin
                if (rsp_valid) begin
                    state_d = StIdle;
                end
`ifdef BUS_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
`endif
            end
            StErrResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output logic: grants, device forwarding and host responses (all gated by reset)
    always_comb begin
        host_gnt_o     = '0;
        host_rvalid_o  = '0;
        host_rdata_o   = '0;
        host_err_o     = '0;
        device_req_o   = '0;
        device_addr_o  = '0;
        device_we_o    = '0;
        device_be_o    = '0;
        device_wdata_o = '0;
        if (!rst_i) begin
            unique case (state_q)
                StIdle: begin
                    if (arb_valid) begin
                        host_gnt_o[arb_idx] = 1'b1;
                        if (dec_hit) begin
                            device_req_o[dec_idx]   = 1'b1;
                            device_addr_o[dec_idx]  = host_addr_i[arb_idx];
                            device_we_o[dec_idx]    = host_we_i[arb_idx];
                            device_be_o[dec_idx]    = host_be_i[arb_idx];
                            device_wdata_o[dec_idx] = host_wdata_i[arb_idx];
                        end
                    end
                end
                StWait: begin
                    if (rsp_valid) begin
                        host_rvalid_o[host_q] = 1'b1;
                        host_rdata_o[host_q]  = rsp_data;
                        host_err_o[host_q]    = rsp_err;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (timeout_hit) begin
                        host_rvalid_o[host_q] = 1'b1;
                        host_err_o[host_q]    = 1'b1;
                    end
`endif
                end
                StErrResp: begin
                    host_rvalid_o[host_q] = 1'b1;
                    host_err_o[host_q]    = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_rr_xbar.sv
// Directed, table-driven bench for bus_rr_xbar (default build, 3 hosts x 7 devices).
module tb_bus_rr_xbar;

    localparam int unsigned NH = 3;
    localparam int unsigned ND = 7;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;

    localparam logic [31:0] W0  = 32'hAAAA_0000;
    localparam logic [31:0] W1  = 32'hBBBB_0001;
    localparam logic [31:0] W2  = 32'hCCCC_0002;
    localparam logic [31:0] A0D = 32'h0010_0004;
    localparam logic [31:0] A1D = 32'h8000_1000;
    localparam logic [31:0] A2D = 32'h8000_0010;

    logic clk = 1'b0;
    logic rst_i;
    logic [NH-1:0]                 host_req_i;
    logic [NH-1:0]                 host_gnt_o;
    logic [NH-1:0][AW-1:0]         host_addr_i;
    logic [NH-1:0]                 host_we_i;
    logic [NH-1:0][DW/8-1:0]       host_be_i;
    logic [NH-1:0][DW-1:0]         host_wdata_i;
    logic [NH-1:0]                 host_rvalid_o;
    logic [NH-1:0][DW-1:0]         host_rdata_o;
    logic [NH-1:0]                 host_err_o;
    logic [ND-1:0]                 device_req_o;
    logic [ND-1:0][AW-1:0]         device_addr_o;
    logic [ND-1:0]                 device_we_o;
    logic [ND-1:0][DW/8-1:0]       device_be_o;
    logic [ND-1:0][DW-1:0]         device_wdata_o;
    logic [ND-1:0]                 device_rvalid_i;
    logic [ND-1:0][DW-1:0]         device_rdata_i;
    logic [ND-1:0]                 device_err_i;
    logic [ND-1:0][AW-1:0]         cfg_device_addr_base;
    logic [ND-1:0][AW-1:0]         cfg_device_addr_mask;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bus_rr_xbar #(
        .NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW), .TimeoutCycles(255)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst_i),
        .host_req_i           (host_req_i),
        .host_gnt_o           (host_gnt_o),
        .host_addr_i          (host_addr_i),
        .host_we_i            (host_we_i),
        .host_be_i            (host_be_i),
        .host_wdata_i         (host_wdata_i),
        .host_rvalid_o        (host_rvalid_o),
        .host_rdata_o         (host_rdata_o),
        .host_err_o           (host_err_o),
        .device_req_o         (device_req_o),
        .device_addr_o        (device_addr_o),
        .device_we_o          (device_we_o),
        .device_be_o          (device_be_o),
        .device_wdata_o       (device_wdata_o),
        .device_rvalid_i      (device_rvalid_i),
        .device_rdata_i       (device_rdata_i),
        .device_err_i         (device_err_i),
        .cfg_device_addr_base (cfg_device_addr_base),
        .cfg_device_addr_mask (cfg_device_addr_mask)
    );

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic [31:0] a0, a1, a2;
        logic [2:0]  we;
        logic [6:0]  drv;
        logic [31:0] drd;
        logic [6:0]  derr;
        logic [2:0]  egnt;
        logic [6:0]  edreq;
        logic [2:0]  erv, eerr;
        logic [31:0] erd, eda, edw;
        logic [6:0]  edwe;
    } vec_t;

    function automatic vec_t mk(
        input logic r, input logic [2:0] req,
        input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
        input logic [2:0] we, input logic [6:0] drv, input logic [31:0] drd, input logic [6:0] derr,
        input logic [2:0] egnt, input logic [6:0] edreq, input logic [2:0] erv, input logic [2:0] eerr,
        input logic [31:0] erd, input logic [31:0] eda, input logic [31:0] edw, input logic [6:0] edwe);
        vec_t v;
        v.rst = r;  v.req = req; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.we = we;
        v.drv = drv; v.drd = drd; v.derr = derr;
        v.egnt = egnt; v.edreq = edreq; v.erv = erv; v.eerr = eerr;
        v.erd = erd; v.eda = eda; v.edw = edw; v.edwe = edwe;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_i           = v.rst;
        host_req_i      = v.req;
        host_addr_i[0]  = v.a0;
        host_addr_i[1]  = v.a1;
        host_addr_i[2]  = v.a2;
        host_we_i       = v.we;
        device_rvalid_i = v.drv;
        device_err_i    = v.derr;
        for (int d = 0; d < ND; d++) device_rdata_i[d] = v.drd;
    endtask

    task automatic check(input vec_t v, input string tag);
        logic [NH-1:0][DW-1:0] exp_rd;
        logic [ND-1:0][AW-1:0] exp_da;
        logic [ND-1:0][DW-1:0] exp_dw;
        for (int h = 0; h < NH; h++) exp_rd[h] = v.erv[h] ? v.erd : 32'h0;
        for (int d = 0; d < ND; d++) begin
            exp_da[d] = v.edreq[d] ? v.eda : 32'h0;
            exp_dw[d] = v.edreq[d] ? v.edw : 32'h0;
        end
        cmp({tag, " gnt"},    256'(host_gnt_o),     256'(v.egnt));
        cmp({tag, " dreq"},   256'(device_req_o),   256'(v.edreq));
        cmp({tag, " rvalid"}, 256'(host_rvalid_o),  256'(v.erv));
        cmp({tag, " err"},    256'(host_err_o),     256'(v.eerr));
        cmp({tag, " rdata"},  256'(host_rdata_o),   256'(exp_rd));
        cmp({tag, " daddr"},  256'(device_addr_o),  256'(exp_da));
        cmp({tag, " dwdata"}, 256'(device_wdata_o), 256'(exp_dw));
        cmp({tag, " dwe"},    256'(device_we_o),    256'(v.edwe));
    endtask

    // One cycle: drive just after the active edge, check combinational outputs mid-cycle
    task automatic step(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        drive(v);
        #1;
        check(v, tag);
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        rst_i           = 1'b1;
        host_req_i      = '0;
        host_addr_i     = '0;
        host_we_i       = '0;
        device_rvalid_i = '0;
        device_rdata_i  = '0;
        device_err_i    = '0;
        host_be_i       = '1;
        host_wdata_i[0] = W0;
        host_wdata_i[1] = W1;
        host_wdata_i[2] = W2;
        // Ram, Gpio, Timer, spare devices; device 5 overlaps Ram with a wider window
        cfg_device_addr_base[0] = 32'h0010_0000; cfg_device_addr_mask[0] = 32'hFFFF_0000;
        cfg_device_addr_base[1] = 32'h8000_0000; cfg_device_addr_mask[1] = 32'hFFFF_F000;
        cfg_device_addr_base[2] = 32'h8000_1000; cfg_device_addr_mask[2] = 32'hFFFF_F000;
        cfg_device_addr_base[3] = 32'h8000_2000; cfg_device_addr_mask[3] = 32'hFFFF_F000;
        cfg_device_addr_base[4] = 32'h8000_3000; cfg_device_addr_mask[4] = 32'hFFFF_F000;
        cfg_device_addr_base[5] = 32'h0010_0000; cfg_device_addr_mask[5] = 32'hFFF0_0000;
        cfg_device_addr_base[6] = 32'h8000_6000; cfg_device_addr_mask[6] = 32'hFFFF_F000;

        //              rst req     a0           a1            a2            we      drv        drd           derr       | egnt   edreq      erv     eerr    erd           eda           edw  edwe
        tbl.push_back(mk(1, 3'b111, A0D,         A1D,          A2D,          3'b000, 7'h00,     32'h0,        7'h00,       3'b000, 7'h00,     3'b000, 3'b000, 32'h0,        32'h0,        32'h0, 7'h00));
        tbl.push_back(mk(1, 3'b000, A0D,         A1D,          A2D,          3'b000, 7'h7F,     32'h1234_5678,7'h00,       3'b000, 7'h00,     3'b000, 3'b000, 32'h0,        32'h0,        32'h0, 7'h00));
        tbl.push_back(mk(0, 3'b001, A0D,         A1D,          A2D,          3'b000, 7'h00,     32'h0,        7'h00,       3'b001, 7'b0000001,3'b000, 3'b000, 32'h0,        A0D,          W0,    7'h00));
        tbl.push_back(mk(0, 3'b000, A0D,         A1D,          A2D,          3'b000, 7'b0000001,32'hDEAD_BEEF,7'h00,       3'b000, 7'h00,     3'b001, 3'b000, 32'hDEAD_BEEF,32'h0,        32'h0, 7'h00));
        tbl.push_back(mk(1, 3'b000, A0D,         A1D,          A2D,          3'b000, 7'h00,     32'h0,        7'h00,       3'b000, 7'h00,     3'b000, 3'b000, 32'h0,        32'h0,        32'h0, 7'h00));
        tbl.push_back(mk(0, 3'b111, A0D,         A1D,          A2D,          3'b000, 7'h00,     32'h0,        7'h00,       3'b001, 7'b0000001,3'b000, 3'b000, 32'h0,        A0D,          W0,    7'h00));
        tbl.push_back(mk(0, 3'b111, A0D,         A1D,          A2D,          3'b000, 7'b0000001,32'h1111_1111,7'h00,       3'b000, 7'h00,     3'b001, 3'b000, 32'h1111_1111,32'h0,        32'h0, 7'h00));
        tbl.push_back(mk(0, 3'b111, A0D,         A1D,          A2D,          3'b010, 7'h00,     32'h0,        7'h00,       3'b010, 7'b0000100,3'b000, 3'b000, 32'h0,        A1D,          W1,    7'b0000100));
        tbl.push_back(mk(0, 3'b111, A0D,         A1D,          A2D,          3'b010, 7'b0000100,32'h2222_2222,7'b0000100,  3'b000, 7'h00,     3'b010, 3'b010, 32'h2222_2222,32'h0,        32'h0, 7'h00));
        tbl.push_back(mk(0, 3'b111, A0D,         A1D,          A2D,          3'b000, 7'h00,     32'h0,        7'h00,       3'b100, 7'b0000010,3'b000, 3'b000, 32'h0,        A2D,          W2,    7'h00));
        tbl.push_back(mk(0, 3'b111, A0D,         A1D,          A2D,          3'b000, 7'b0000010,32'h3333_3333,7'h00,       3'b000, 7'h00,     3'b100, 3'b000, 32'h3333_3333,32'h0,        32'h0, 7'h00));
        tbl.push_back(mk(0, 3'b111, A0D,         A1D,          A2D,          3'b000, 7'h00,     32'h0,        7'h00,       3'b001, 7'b0000001,3'b000, 3'b000, 32'h0,        A0D,          W0,    7'h00));
        tbl.push_back(mk(0, 3'b000, A0D,         A1D,          A2D,          3'b000, 7'b0000001,32'h4444_4444,7'h00,       3'b000, 7'h00,     3'b001, 3'b000, 32'h4444_4444,32'h0,        32'h0, 7'h00));
        tbl.push_back(mk(0, 3'b010, A0D,         32'h4000_0000,A2D,          3'b010, 7'h00,     32'h0,        7'h00,       3'b010, 7'h00,     3'b000, 3'b000, 32'h0,        32'h0,        32'h0, 7'h00));
        tbl.push_back(mk(0, 3'b000, A0D,         32'h4000_0000,A2D,          3'b000, 7'h7F,     32'h5555_5555,7'h00,       3'b000, 7'h00,     3'b010, 3'b010, 32'h0,        32'h0,        32'h0, 7'h00));
        tbl.push_back(mk(0, 3'b000, A0D,         A1D,          A2D,          3'b000, 7'h7F,     32'h6666_6666,7'h7F,       3'b000, 7'h00,     3'b000, 3'b000, 32'h0,        32'h0,        32'h0, 7'h00));
        tbl.push_back(mk(0, 3'b100, A0D,         A1D,          32'h0018_0000,3'b000, 7'h00,     32'h0,        7'h00,       3'b100, 7'b0100000,3'b000, 3'b000, 32'h0,        32'h0018_0000,W2,    7'h00));
        tbl.push_back(mk(0, 3'b000, A0D,         A1D,          A2D,          3'b000, 7'b0100000,32'h7777_7777,7'h00,       3'b000, 7'h00,     3'b100, 3'b000, 32'h7777_7777,32'h0,        32'h0, 7'h00));
        tbl.push_back(mk(0, 3'b001, A0D,         A1D,          A2D,          3'b000, 7'h00,     32'h0,        7'h00,       3'b001, 7'b0000001,3'b000, 3'b000, 32'h0,        A0D,          W0,    7'h00));
        tbl.push_back(mk(0, 3'b000, A0D,         A1D,          A2D,          3'b000, 7'b0000001,32'h8888_8888,7'h00,       3'b000, 7'h00,     3'b001, 3'b000, 32'h8888_8888,32'h0,        32'h0, 7'h00));

        foreach (tbl[i]) step(tbl[i], $sformatf("v%0d", i));

        // Timer answers 5 cycles after grant; Gpio strays meanwhile; host1 waits
        step(mk(0, 3'b001, 32'h8000_1004, 32'h8000_0000, A2D, 3'b000, 7'h00, 32'h0, 7'h00,
                3'b001, 7'b0000100, 3'b000, 3'b000, 32'h0, 32'h8000_1004, W0, 7'h00), "lat c0");
        step(mk(0, 3'b010, A0D, 32'h8000_0000, A2D, 3'b000, 7'h00, 32'h0, 7'h00,
                3'b000, 7'h00, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 7'h00), "lat c1");
        step(mk(0, 3'b010, A0D, 32'h8000_0000, A2D, 3'b000, 7'b0000010, 32'hBAD0_BAD0, 7'b0000010,
                3'b000, 7'h00, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 7'h00), "lat c2");
        step(mk(0, 3'b010, A0D, 32'h8000_0000, A2D, 3'b000, 7'b0000010, 32'hBAD0_BAD0, 7'h00,
                3'b000, 7'h00, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 7'h00), "lat c3");
        step(mk(0, 3'b010, A0D, 32'h8000_0000, A2D, 3'b000, 7'h00, 32'h0, 7'h00,
                3'b000, 7'h00, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 7'h00), "lat c4");
        step(mk(0, 3'b010, A0D, 32'h8000_0000, A2D, 3'b000, 7'b0000110, 32'h7173_0005, 7'h00,
                3'b000, 7'h00, 3'b001, 3'b000, 32'h7173_0005, 32'h0, 32'h0, 7'h00), "lat c5");
        step(mk(0, 3'b010, A0D, 32'h8000_0000, A2D, 3'b000, 7'h00, 32'h0, 7'h00,
                3'b010, 7'b0000010, 3'b000, 3'b000, 32'h0, 32'h8000_0000, W1, 7'h00), "lat c6");
        step(mk(0, 3'b000, A0D, 32'h8000_0000, A2D, 3'b000, 7'b0000010, 32'h0000_6060, 7'h00,
                3'b000, 7'h00, 3'b010, 3'b000, 32'h0000_6060, 32'h0, 32'h0, 7'h00), "lat c7");

        // Silent device: no timeout in the default build, the bus waits past 255 cycles
        step(mk(0, 3'b100, A0D, A1D, 32'h8000_1008, 3'b000, 7'h00, 32'h0, 7'h00,
                3'b100, 7'b0000100, 3'b000, 3'b000, 32'h0, 32'h8000_1008, W2, 7'h00), "hold gnt");
        v = mk(0, 3'b011, A0D, A1D, A2D, 3'b000, 7'b1111011, 32'hF00D_F00D, 7'b1111011,
               3'b000, 7'h00, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 7'h00);
        for (int c = 0; c < 300; c++) step(v, $sformatf("hold w%0d", c));
        step(mk(0, 3'b011, A0D, A1D, A2D, 3'b000, 7'b0000100, 32'h0C0F_FEE0, 7'h00,
                3'b000, 7'h00, 3'b100, 3'b000, 32'h0C0F_FEE0, 32'h0, 32'h0, 7'h00), "hold rsp");

        // Reset mid-WAIT: abandoned transaction never answers, pointer back to host0
        step(mk(0, 3'b011, A0D, A1D, A2D, 3'b000, 7'h00, 32'h0, 7'h00,
                3'b001, 7'b0000001, 3'b000, 3'b000, 32'h0, A0D, W0, 7'h00), "rst c0");
        step(mk(1, 3'b111, A0D, A1D, A2D, 3'b000, 7'h00, 32'h0, 7'h00,
                3'b000, 7'h00, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 7'h00), "rst c1");
        step(mk(0, 3'b111, A0D, A1D, A2D, 3'b000, 7'b0000001, 32'h9999_9999, 7'h00,
                3'b001, 7'b0000001, 3'b000, 3'b000, 32'h0, A0D, W0, 7'h00), "rst c2");
        step(mk(0, 3'b000, A0D, A1D, A2D, 3'b000, 7'b0000001, 32'hAAAA_5555, 7'h00,
                3'b000, 7'h00, 3'b001, 3'b000, 32'hAAAA_5555, 32'h0, 32'h0, 7'h00), "rst c3");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
